// File: rtl/sipo_load_ctrl.sv
// sipo_load_ctrl: streams serial bits into an external 32-bit SIPO register and writes each completed word to a weight buffer
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   start_i       begins a frame when sampled high in IDLE
//   abort_i       synchronous frame termination, wins over every other event
//   base_addr_i   first write address of the frame, latched on frame start
//   s_bit_i       upstream serial data bit
//   s_valid_i     s_bit_i is valid this cycle
//   s_ready_o     controller accepts s_bit_i this cycle (combinational)
//   sh_en_o       SIPO shift enable (combinational)
//   sh_si_o       SIPO serial input (combinational)
//   sh_po_i       SIPO parallel output, first accepted bit lands in bit 0
//   wr_en_o       one-cycle weight-buffer write strobe (registered)
//   wr_addr_o     weight-buffer write address (registered)
//   wr_data_o     weight-buffer write data (registered)
//   busy_o        high from frame start until the block is idle again (registered)
//   done_o        one-cycle pulse on normal frame completion (registered)
module sipo_load_ctrl #(
  parameter int NUM_WORDS = 16,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              s_bit_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic              sh_en_o,
  output logic              sh_si_o,
  input  logic [31:0]       sh_po_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int WC_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_WORDS - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, FINISH} state_t;
  state_t              state_q, state_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept;
  logic                last_bit;
  logic                frame_start;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  assign accept      = (state_q == SHIFT) && s_valid_i;
  assign last_bit    = accept && (bit_cnt_q == 5'd31);
  assign frame_start = (state_q == IDLE) && (state_d == SHIFT);
  always_comb begin
    state_d = abort_i                ? IDLE :
              (state_q == IDLE)      ? (start_i ? SHIFT : IDLE) :
              (state_q == SHIFT)     ? (last_bit ? CAPTURE : SHIFT) :
              (state_q == CAPTURE)   ? ((word_cnt_q == LAST_WORD) ? FINISH : SHIFT) :
                                       IDLE;
  end
  // Counters are cleared whenever the frame is not running so that every
  // frame, including one started right after an abort, begins from bit 0.
  // busy stays high through the edge leaving FINISH, so it falls one cycle
  // after done unless start immediately opens the next frame.
  always_comb begin
    s_ready_o  = (state_q == SHIFT);
    sh_en_o    = accept;
    sh_si_o    = s_ready_o && s_bit_i;
    bit_cnt_d  = (state_q == IDLE || state_d == IDLE) ? 5'd0 :
                 accept ? bit_cnt_q + 5'd1 : bit_cnt_q;
    word_cnt_d = (state_q == IDLE || state_d == IDLE) ? '0 :
                 (state_q == CAPTURE && state_d == SHIFT) ? word_cnt_q + 1'b1 : word_cnt_q;
    base_d     = frame_start ? base_addr_i : base_q;
    wr_en_d    = (state_q == CAPTURE) && !abort_i;
    wr_addr_d  = wr_en_d ? base_q + ADDR_W'(word_cnt_q) : wr_addr_q;
    wr_data_d  = wr_en_d ? sh_po_i : wr_data_q;
    done_d     = (state_q == FINISH) && !abort_i;
    busy_d     = !abort_i && (state_d != IDLE || state_q == FINISH);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      base_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      base_q     <= base_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
endmodule

// File: tb/tb_sipo_load_ctrl.sv
// tb_sipo_load_ctrl: directed scoreboard bench for sipo_load_ctrl with a behavioural SIPO register
module tb_sipo_load_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  base = 8'h00;
  logic        s_bit = 1'b1;
  logic        s_valid = 1'b1;
  logic        s_ready, sh_en, sh_si, wr_en, busy, done;
  logic [31:0] sh_po = 32'h0;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        en_n = 1'b0;
  logic        si_n = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          ecnt = 0;
  int          s_edge = 0;
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int   dq[$];
  sipo_load_ctrl #(.NUM_WORDS(2), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .base_addr_i(base),
    .s_bit_i(s_bit), .s_valid_i(s_valid), .s_ready_o(s_ready), .sh_en_o(sh_en),
    .sh_si_o(sh_si), .sh_po_i(sh_po), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;
  // External SIPO: shift enable/bit are sampled mid-cycle to stay clear of the edge.
  always @(negedge clk) begin
    en_n <= sh_en;
    si_n <= sh_si;
  end
  always @(posedge clk) if (en_n) sh_po <= {si_n, sh_po[31:1]};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (done) dq.push_back(ecnt - s_edge);
    if (wr_en) begin
      check("wr_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e_mon = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e_mon.a));
        check("wr_data", wr_data, e_mon.d);
        if (e_mon.c >= 0) check("wr_cycle", ecnt - s_edge, e_mon.c);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b, input bit gap);
    bit acc;
    acc = 1'b0;
    s_valid = 1'b1;
    s_bit = b;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = sh_en;
      tick();
    end
    s_valid = 1'b0;
    check("bit_accepted", 32'(acc), 1);
    if (gap) tick();
  endtask
  task automatic send_word(input logic [31:0] w, input bit gap, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[i], gap);
  endtask
  task automatic start_frame(input logic [7:0] b, input bit keep);
    base = b;
    start = 1'b1;
    s_edge = ecnt + 1;
    tick();
    if (!keep) start = 1'b0;
  endtask
  task automatic wait_idle(output int rel);
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(busy), 0);
    rel = ecnt - s_edge;
  endtask
  task automatic check_done(input int n, input int t0, input int t1);
    check("done_count", dq.size(), n);
    if (n > 0) check("done_cycle0", dq.size() > 0 ? dq[0] : -1, t0);
    if (n > 1) check("done_cycle1", dq.size() > 1 ? dq[1] : -1, t1);
    dq.delete();
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    int rel;
    #2 rst_n = 1'b0;
    #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_sh_en", 32'(sh_en), 0);
    check("rst_sh_si", 32'(sh_si), 0);
    s_valid = 1'b0;
    s_bit = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_busy", 32'(busy), 0);
    check("idle_s_ready", 32'(s_ready), 0);
    // Basic frame, continuous valid
    sb.push_back('{8'h10, 32'h0000_0001, 33});
    sb.push_back('{8'h11, 32'h8000_0000, 66});
    start_frame(8'h10, 0);
    check("busy_after_start", 32'(busy), 1);
    check("s_ready_shift", 32'(s_ready), 1);
    send_word(32'h0000_0001, 0, 32);
    send_word(32'h8000_0000, 0, 32);
    wait_idle(rel);
    check("busy_low_cycle", rel, 68);
    check_done(1, 67, 0);
    // Same frame with valid gaps after every bit
    sb.push_back('{8'h10, 32'h0000_0001, 64});
    sb.push_back('{8'h11, 32'h8000_0000, 128});
    start_frame(8'h10, 0);
    send_word(32'h0000_0001, 1, 32);
    send_word(32'h8000_0000, 1, 32);
    wait_idle(rel);
    check_done(1, 129, 0);
    // Address wrap
    sb.push_back('{8'hFF, 32'hA5A5_5A5A, 33});
    sb.push_back('{8'h00, 32'h1234_5678, 66});
    start_frame(8'hFF, 0);
    send_word(32'hA5A5_5A5A, 0, 32);
    send_word(32'h1234_5678, 0, 32);
    wait_idle(rel);
    check_done(1, 67, 0);
    // Abort 20 bits into the second word
    sb.push_back('{8'h20, 32'hDEAD_BEEF, 33});
    start_frame(8'h20, 0);
    send_word(32'hDEAD_BEEF, 0, 32);
    send_word(32'hCAFE_F00D, 0, 20);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_wr_en", 32'(wr_en), 0);
    check("abort_done", 32'(done), 0);
    check("abort_s_ready", 32'(s_ready), 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", 32'(busy), 0);
    tick();
    check("abort_start_s_ready", 32'(s_ready), 0);
    check_done(0, 0, 0);
    check("abort_sb_empty", sb.size(), 0);
    sb.push_back('{8'h30, 32'h0F0F_0F0F, 33});
    sb.push_back('{8'h31, 32'hF0F0_F0F1, 66});
    start_frame(8'h30, 0);
    send_word(32'h0F0F_0F0F, 0, 32);
    send_word(32'hF0F0_F0F1, 0, 32);
    wait_idle(rel);
    check_done(1, 67, 0);
    // Reset during CAPTURE
    start_frame(8'h40, 0);
    send_word(32'h5555_5555, 0, 32);
    check("capture_s_ready", 32'(s_ready), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 32'(wr_en), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_wr_addr", 32'(wr_addr), 0);
    check("midrst_wr_data", wr_data, 0);
    check("midrst_s_ready", 32'(s_ready), 0);
    tick();
    check("midrst_wr_en_edge", 32'(wr_en), 0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("postrst_busy", 32'(busy), 0);
    check("postrst_s_ready", 32'(s_ready), 0);
    check_done(0, 0, 0);
    // start held high across two frames
    sb.push_back('{8'h50, 32'h1111_2222, 33});
    sb.push_back('{8'h51, 32'h3333_4444, 66});
    sb.push_back('{8'h50, 32'h5555_6666, 101});
    sb.push_back('{8'h51, 32'h7777_8888, 134});
    start_frame(8'h50, 1);
    send_word(32'h1111_2222, 0, 32);
    send_word(32'h3333_4444, 0, 32);
    send_word(32'h5555_6666, 0, 32);
    send_word(32'h7777_8888, 0, 32);
    start = 1'b0;
    wait_idle(rel);
    check("held_busy_low_cycle", rel, 136);
    check_done(2, 67, 135);
    tick();
    check("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
